// File: rtl/pwm_tach_pkg.sv
// -----------------------------------------------------------------------------
// pwm_tach_pkg
// Shared definitions for the PWM/tach fan controller: Wishbone register
// offsets, the MIN field position inside the DUTYi word, default parameter
// values and the address decoder used by the top level.
// -----------------------------------------------------------------------------
package pwm_tach_pkg;

  // Global register offsets (byte addresses)
  localparam logic [7:0] CTRL_OFS     = 8'h00;
  localparam logic [7:0] WIN_OFS      = 8'h04;
  localparam logic [7:0] IRQ_STAT_OFS = 8'h08;
  localparam logic [7:0] IRQ_MASK_OFS = 8'h0C;

  // Per-channel register block: CH_BASE + CH_STRIDE*i + {DUTY_OFS, TACH_OFS}
  localparam logic [7:0] CH_BASE      = 8'h10;
  localparam logic [7:0] CH_STRIDE    = 8'h08;
  localparam logic [7:0] DUTY_OFS     = 8'h00;
  localparam logic [7:0] TACH_OFS     = 8'h04;

  // LSB of the MIN threshold inside the DUTYi word
  localparam int MIN_LSB = 16;

  // Default parameter values
  localparam int          NCH_DEF         = 4;
  localparam int          PWM_W_DEF       = 10;
  localparam int          TCH_W_DEF       = 16;
  localparam int          WIN_W_DEF       = 27;
  localparam int unsigned WIN_DEFAULT_CYC = 50_000_000;
  localparam int          ADR_W_DEF       = 6;

  // Which register an access targets
  typedef enum logic [2:0] {
    REG_NONE,
    REG_CTRL,
    REG_WIN,
    REG_STAT,
    REG_MASK,
    REG_DUTY,
    REG_TACH
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [2:0] ch;
  } reg_dec_t;

  // Decode a byte address (bits [1:0] ignored) into register + channel.
  // Channel blocks beyond nch decode to REG_NONE, so they read 0 and
  // swallow writes.
  function automatic reg_dec_t decode_addr(input logic [7:0] adr,
                                           input int         nch);
    logic [7:0] a;
    logic [7:0] off;
    reg_dec_t   d;
    a     = {adr[7:2], 2'b00};
    off   = '0;
    d.sel = REG_NONE;
    d.ch  = '0;
    case (a)
      CTRL_OFS:     d.sel = REG_CTRL;
      WIN_OFS:      d.sel = REG_WIN;
      IRQ_STAT_OFS: d.sel = REG_STAT;
      IRQ_MASK_OFS: d.sel = REG_MASK;
      default: begin
        if (a >= CH_BASE) begin
          off = a - CH_BASE;
          if (int'(off[7:3]) < nch) begin
            d.ch  = off[5:3];
            d.sel = (off[2:0] == TACH_OFS[2:0]) ? REG_TACH : REG_DUTY;
          end
        end
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pwm_tach_ctrl_tach_chan.sv
// -----------------------------------------------------------------------------
// tach_chan
// One tachometer channel: 3-flop synchroniser, falling-edge detect,
// saturating running count and a latched result register.
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   tach     asynchronous tach input from the fan
//   win_tc   terminal cycle of the measurement window (latch + restart)
//   win_clr  clears the running count (window rewritten or halted)
//   count    latched count of the last completed window
// -----------------------------------------------------------------------------
module tach_chan #(
  parameter int TCH_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tach,
  input  logic             win_tc,
  input  logic             win_clr,
  output logic [TCH_W-1:0] count
);

  logic [2:0]       sync;
  logic             fall;
  logic [TCH_W-1:0] run;

  // sync[1:0] resolve metastability; sync[2] is the previous settled value.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[1:0], tach};
  end

  assign fall = sync[2] & ~sync[1];

  // An edge seen on the terminal cycle starts the next window at 1, so no
  // edge is ever dropped between windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       run <= '0;
    else if (win_clr)                 run <= '0;
    else if (win_tc)                  run <= TCH_W'(fall);
    else if (fall && (run != '1))     run <= run + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count <= '0;
    else if (win_tc) count <= run;
  end

endmodule

// File: rtl/pwm_tach_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_tach_ctrl
// NCH-channel fan controller on a Wishbone slave port. Each channel drives
// a glitch-free PWM output (duty shadowed and applied at period end) and
// measures its tach input over a programmable window. A channel whose
// latched count falls below its MIN threshold raises a maskable IRQ.
//
// Ports
//   CLK_I      system clock
//   RST_N_I    asynchronous active-low reset
//   PTC_STB_I  Wishbone strobe
//   PTC_WE_I   write enable
//   PTC_ADR_I  byte address, [1:0] ignored
//   PTC_DAT_I  write data
//   PTC_SEL_I  byte selects, ignored (full-word access only)
//   PTC_ACK_O  single-cycle acknowledge
//   PTC_DAT_O  registered read data, valid with ACK
//   PTC_ERR_O  tied 0
//   PTC_RTY_O  tied 0
//   PWM_O      PWM outputs, one per channel
//   TACH_I     asynchronous tach inputs, one per channel
//   IRQ_O      level interrupt, |(IRQ_STAT & IRQ_MASK)
//
// Register map
//   0x00 CTRL      [NCH-1:0] channel enable
//   0x04 WIN       [WIN_W-1:0] window length in cycles, 0 halts measurement
//   0x08 IRQ_STAT  [NCH-1:0] stall flags, write-1-to-clear
//   0x0C IRQ_MASK  [NCH-1:0] 1 = interrupt enabled
//   0x10+8i DUTYi  [PWM_W:0] duty, [16+TCH_W-1:16] MINi
//   0x14+8i TACHi  latched tach count, read-only
//
// ADR_W is at most 8; the decoder works on an 8-bit byte address.
// -----------------------------------------------------------------------------
module pwm_tach_ctrl
  import pwm_tach_pkg::*;
#(
  parameter int          NCH         = NCH_DEF,
  parameter int          PWM_W       = PWM_W_DEF,
  parameter int          TCH_W       = TCH_W_DEF,
  parameter int          WIN_W       = WIN_W_DEF,
  parameter int unsigned WIN_DEFAULT = WIN_DEFAULT_CYC,
  parameter int          ADR_W       = ADR_W_DEF
) (
  input  logic             CLK_I,
  input  logic             RST_N_I,
  input  logic             PTC_STB_I,
  input  logic             PTC_WE_I,
  input  logic [ADR_W-1:0] PTC_ADR_I,
  input  logic [31:0]      PTC_DAT_I,
  input  logic [3:0]       PTC_SEL_I,
  output logic             PTC_ACK_O,
  output logic [31:0]      PTC_DAT_O,
  output logic             PTC_ERR_O,
  output logic             PTC_RTY_O,
  output logic [NCH-1:0]   PWM_O,
  input  logic [NCH-1:0]   TACH_I,
  output logic             IRQ_O
);

  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             ack;
  logic [31:0]      dat;

  logic [NCH-1:0]   en;
  logic [NCH-1:0]   irq_stat;
  logic [NCH-1:0]   irq_mask;
  logic [WIN_W-1:0] win;
  logic [WIN_W-1:0] wcnt;
  logic             latch_d;

  logic [PWM_W-1:0] pcnt;
  logic [PWM_W:0]   duty_shadow [NCH];
  logic [PWM_W:0]   duty_act    [NCH];
  logic [TCH_W-1:0] min_thr     [NCH];
  logic [TCH_W-1:0] tach_cnt    [NCH];
  logic [NCH-1:0]   pwm;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [7:0]       adr8;
  reg_dec_t         dec;
  logic [CH_W-1:0]  ch;
  logic             access;
  logic             wr;
  logic             win_wr;
  logic             stat_wr;
  logic [31:0]      rdata;

  assign adr8    = 8'(PTC_ADR_I);
  assign dec     = decode_addr(adr8, NCH);
  assign ch      = dec.ch[CH_W-1:0];
  assign access  = PTC_STB_I & ~ack;
  assign wr      = access & PTC_WE_I;
  assign win_wr  = wr && (dec.sel == REG_WIN);
  assign stat_wr = wr && (dec.sel == REG_STAT);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    case (dec.sel)
      REG_CTRL: rdata[NCH-1:0]   = en;
      REG_WIN:  rdata[WIN_W-1:0] = win;
      REG_STAT: rdata[NCH-1:0]   = irq_stat;
      REG_MASK: rdata[NCH-1:0]   = irq_mask;
      REG_DUTY: begin
        rdata[PWM_W:0]           = duty_shadow[ch];
        rdata[MIN_LSB +: TCH_W]  = min_thr[ch];
      end
      REG_TACH: rdata[TCH_W-1:0] = tach_cnt[ch];
      default:  ;
    endcase
  end

  // ACK pulses for one cycle; back-to-back strobes get every other cycle.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      ack <= 1'b0;
      dat <= '0;
    end else begin
      ack <= access;
      if (access) dat <= PTC_WE_I ? '0 : rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  // NOTE: the per-channel arrays are a handful of flops, not a RAM, so they
  // are reset like any other register.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      en       <= '0;
      win      <= WIN_W'(WIN_DEFAULT);
      irq_mask <= '0;
      for (int i = 0; i < NCH; i++) begin
        duty_shadow[i] <= '0;
        min_thr[i]     <= '0;
      end
    end else if (wr) begin
      case (dec.sel)
        REG_CTRL: en       <= PTC_DAT_I[NCH-1:0];
        REG_WIN:  win      <= PTC_DAT_I[WIN_W-1:0];
        REG_MASK: irq_mask <= PTC_DAT_I[NCH-1:0];
        REG_DUTY: begin
          duty_shadow[ch] <= PTC_DAT_I[PWM_W:0];
          min_thr[ch]     <= PTC_DAT_I[MIN_LSB +: TCH_W];
        end
        default:  ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // PWM
  // ---------------------------------------------------------------------------
  // The active duty only changes on the last count of a period, so a period
  // is never truncated or extended by a write landing mid-period.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      pcnt <= '0;
      pwm  <= '0;
      for (int i = 0; i < NCH; i++) duty_act[i] <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (pcnt == '1) duty_act[i] <= duty_shadow[i];
        // duty >= 2**PWM_W always compares true: constant high
        pwm[i] <= en[i] & ({1'b0, pcnt} < duty_act[i]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement window
  // ---------------------------------------------------------------------------
  logic win_clr;
  logic win_tc;

  // A WIN write restarts the window; the latch is suppressed on that cycle
  // so the previous result stays readable.
  assign win_clr = win_wr | (win == '0);
  assign win_tc  = ~win_wr & (win != '0) & (wcnt == win);

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      wcnt    <= '0;
      latch_d <= 1'b0;
    end else begin
      latch_d <= win_tc;
      if (win_clr)     wcnt <= '0;
      else if (win_tc) wcnt <= WIN_W'(1);
      else             wcnt <= wcnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_tach
    tach_chan #(
      .TCH_W   (TCH_W)
    ) u_tach (
      .clk     (CLK_I),
      .rst_n   (RST_N_I),
      .tach    (TACH_I[g]),
      .win_tc  (win_tc),
      .win_clr (win_clr),
      .count   (tach_cnt[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Stall detection / IRQ
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] stat_set;
  logic [NCH-1:0] stat_clr;

  // Compared one cycle after the latch, when tach_cnt holds the new result.
  always_comb begin
    stat_set = '0;
    for (int i = 0; i < NCH; i++)
      stat_set[i] = latch_d & en[i] & (tach_cnt[i] < min_thr[i]);
  end

  assign stat_clr = stat_wr ? PTC_DAT_I[NCH-1:0] : '0;

  // Set wins over a simultaneous write-1-to-clear.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) irq_stat <= '0;
    else          irq_stat <= (irq_stat & ~stat_clr) | stat_set;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign PTC_ACK_O = ack;
  assign PTC_DAT_O = dat;
  assign PTC_ERR_O = 1'b0;
  assign PTC_RTY_O = 1'b0;
  assign PWM_O     = pwm;
  assign IRQ_O     = |(irq_stat & irq_mask);

  // Byte selects and the address byte offset carry no information here.
  logic unused_ok;
  assign unused_ok = ^{PTC_SEL_I, PTC_ADR_I, PTC_DAT_I};

endmodule

// File: tb/tb_pwm_tach_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_tach_ctrl
// Directed bench for pwm_tach_ctrl. TCH_W is reduced to 12 so count
// saturation (4095) is reachable within a short run; everything else uses
// the default parameters.
// -----------------------------------------------------------------------------
module tb_pwm_tach_ctrl;

  localparam int NCH   = 4;
  localparam int PWM_W = 10;
  localparam int TCH_W = 12;
  localparam int WIN_W = 27;
  localparam int ADR_W = 6;

  localparam logic [7:0] A_CTRL  = 8'h00;
  localparam logic [7:0] A_WIN   = 8'h04;
  localparam logic [7:0] A_STAT  = 8'h08;
  localparam logic [7:0] A_MASK  = 8'h0C;
  localparam logic [7:0] A_DUTY0 = 8'h10;
  localparam logic [7:0] A_TACH0 = 8'h14;
  localparam logic [7:0] A_DUTY1 = 8'h18;
  localparam logic [7:0] A_TACH1 = 8'h1C;
  localparam logic [7:0] A_DUTY2 = 8'h20;
  localparam logic [7:0] A_TACH2 = 8'h24;
  localparam logic [7:0] A_TACH3 = 8'h2C;
  localparam logic [7:0] A_UNMAP = 8'h30;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stb = 1'b0;
  logic             we = 1'b0;
  logic [ADR_W-1:0] adr = '0;
  logic [31:0]      wdat = '0;
  logic [3:0]       sel = 4'hF;
  logic             ack;
  logic [31:0]      rdat;
  logic             err;
  logic             rty;
  logic [NCH-1:0]   pwm;
  logic [NCH-1:0]   tach;
  logic             irq;

  int               tper [NCH] = '{default: 0};
  int               tcnt [NCH];
  logic [NCH-1:0]   tman = '1;
  logic [NCH-1:0]   tgen;

  int n_chk  = 0;
  int n_fail = 0;

  initial forever #5 clk = ~clk;

  pwm_tach_ctrl #(
    .NCH         (NCH),
    .PWM_W       (PWM_W),
    .TCH_W       (TCH_W),
    .WIN_W       (WIN_W),
    .WIN_DEFAULT (50_000_000),
    .ADR_W       (ADR_W)
  ) dut (
    .CLK_I     (clk),
    .RST_N_I   (rst_n),
    .PTC_STB_I (stb),
    .PTC_WE_I  (we),
    .PTC_ADR_I (adr),
    .PTC_DAT_I (wdat),
    .PTC_SEL_I (sel),
    .PTC_ACK_O (ack),
    .PTC_DAT_O (rdat),
    .PTC_ERR_O (err),
    .PTC_RTY_O (rty),
    .PWM_O     (pwm),
    .TACH_I    (tach),
    .IRQ_O     (irq)
  );

  // Periodic tach source: tper[i] > 0 gives a square wave of that period
  // (low first half), otherwise the line follows tman[i].
  initial begin
    tgen = '1;
    for (int i = 0; i < NCH; i++) tcnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) begin
        if (tper[i] > 0) begin
          tcnt[i] = (tcnt[i] + 1 >= tper[i]) ? 0 : tcnt[i] + 1;
          tgen[i] = (tcnt[i] < tper[i] / 2) ? 1'b0 : 1'b1;
        end
      end
    end
  end

  always_comb begin
    tach = '0;
    for (int i = 0; i < NCH; i++) tach[i] = (tper[i] > 0) ? tgen[i] : tman[i];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = a[ADR_W-1:0]; wdat = d;
    @(negedge clk);
    check("wr_ack", 32'(ack), 32'd1);
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = a[ADR_W-1:0];
    @(negedge clk);
    d = rdat;
    stb = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a,
                          input logic [31:0] exp);
    logic [31:0] d;
    wb_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm[ch]) hi++;
    end
  endtask

  task automatic wait_irq(input string tag, input int limit);
    int k;
    k = 0;
    while (!irq && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(irq), 32'd1);
  endtask

  initial begin
    int   hi, h0, h1, rises0, rises1;
    logic prev, found;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("err_rty", 32'({err, rty}), 32'd0);
    rst_n = 1'b1;
    rd_check("rst_win",   A_WIN,   32'd50_000_000);
    rd_check("rst_ctrl",  A_CTRL,  32'd0);
    rd_check("rst_mask",  A_MASK,  32'd0);
    rd_check("rst_tach0", A_TACH0, 32'd0);
    rd_check("unmapped",  A_UNMAP, 32'd0);

    // ---------------- PWM duty range ----------------
    wb_write(A_DUTY0, 32'd256);
    wb_write(A_CTRL, 32'h1);
    rd_check("duty0_rb", A_DUTY0, 32'd256);
    wb_write(A_TACH0, 32'h123);
    rd_check("tach_ro", A_TACH0, 32'd0);
    wb_write(A_UNMAP, 32'hFFFF_FFFF);
    rd_check("unmapped_wr", A_UNMAP, 32'd0);

    repeat (1100) @(negedge clk);
    count_high(0, 1024, hi);
    check("duty256", 32'(hi), 32'd256);

    wb_write(A_DUTY0, 32'd0);
    repeat (1100) @(negedge clk);
    count_high(0, 1024, hi);
    check("duty0_low", 32'(hi), 32'd0);

    wb_write(A_DUTY0, 32'd1024);
    repeat (1100) @(negedge clk);
    count_high(0, 1024, hi);
    check("duty1024_high", 32'(hi), 32'd1024);

    wb_write(A_DUTY0, 32'd2047);
    repeat (1100) @(negedge clk);
    count_high(0, 1024, hi);
    check("duty2047_high", 32'(hi), 32'd1024);

    // disable: output drops, shadow still writable
    wb_write(A_CTRL, 32'h0);
    @(negedge clk);
    check("disable_low", 32'(pwm[0]), 32'd0);
    wb_write(A_DUTY0, 32'd300);
    rd_check("shadow_dis", A_DUTY0, 32'd300);

    // ---------------- shadowed update, no runt ----------------
    wb_write(A_DUTY1, 32'd100);
    wb_write(A_CTRL, 32'h3);
    repeat (1100) @(negedge clk);
    found = 1'b0;
    prev  = pwm[1];
    for (int i = 0; i < 1100 && !found; i++) begin
      @(negedge clk);
      if (pwm[1] && !prev) found = 1'b1;
      prev = pwm[1];
    end
    check("pwm1_rise", 32'(found), 32'd1);
    // sample 0 is the first high sample of a period
    h0 = 1; h1 = 0; rises0 = 0; rises1 = 0; prev = 1'b1;
    for (int i = 1; i < 2048; i++) begin
      if (i == 500) begin
        stb = 1'b1; we = 1'b1; adr = A_DUTY1[ADR_W-1:0]; wdat = 32'd900;
      end else if (i == 501) begin
        stb = 1'b0; we = 1'b0;
      end
      @(negedge clk);
      if (i < 1024) begin
        if (pwm[1]) h0++;
        if (pwm[1] && !prev) rises0++;
      end else begin
        if (pwm[1]) h1++;
        if (pwm[1] && !prev) rises1++;
      end
      prev = pwm[1];
    end
    check("runt_cur_high", 32'(h0), 32'd100);
    check("runt_cur_rises", 32'(rises0), 32'd0);
    check("runt_next_high", 32'(h1), 32'd900);
    check("runt_next_rises", 32'(rises1), 32'd1);

    // ---------------- tach count ----------------
    tper[1] = 100;
    wb_write(A_WIN, 32'd1000);
    repeat (2600) @(negedge clk);
    rd_check("tach1_10a", A_TACH1, 32'd10);
    repeat (1000) @(negedge clk);
    rd_check("tach1_10b", A_TACH1, 32'd10);

    tper[1] = 2;
    wb_write(A_WIN, 32'd10000);
    repeat (10100) @(negedge clk);
    rd_check("tach1_sat", A_TACH1, 32'd4095);
    tper[1] = 0;

    // ---------------- stall / IRQ ----------------
    wb_write(A_DUTY2, 32'd20 << 16);
    wb_write(A_MASK, 32'h4);
    wb_write(A_CTRL, 32'h4);
    tper[2] = 100;
    wb_write(A_WIN, 32'd1000);
    rd_check("stat_pre", A_STAT, 32'd0);
    wait_irq("irq_first", 1100);
    rd_check("stat_set", A_STAT, 32'h4);

    wb_write(A_STAT, 32'h4);
    check("irq_w1c", 32'(irq), 32'd0);
    rd_check("stat_w1c", A_STAT, 32'd0);
    wait_irq("irq_reset", 1100);

    // W1C landing on the set cycle, 1000 cycles after the set just seen
    wb_write(A_STAT, 32'h4);
    check("irq_w1c2", 32'(irq), 32'd0);
    repeat (997) @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = A_STAT[ADR_W-1:0]; wdat = 32'h4;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    check("set_beats_w1c", 32'(irq), 32'd1);
    rd_check("stat_kept", A_STAT, 32'h4);

    wb_write(A_MASK, 32'h0);
    check("irq_masked", 32'(irq), 32'd0);
    rd_check("stat_masked", A_STAT, 32'h4);

    // ---------------- edge on the terminal cycle ----------------
    wb_write(A_MASK, 32'h4);
    wb_write(A_STAT, 32'h4);
    wait_irq("irq_ref", 1100);
    repeat (996) @(negedge clk);
    tman[3] = 1'b0;
    repeat (10) @(negedge clk);
    tman[3] = 1'b1;
    rd_check("tc_edge_excl", A_TACH3, 32'd0);
    repeat (1000) @(negedge clk);
    rd_check("tc_edge_next", A_TACH3, 32'd1);

    // ---------------- reset mid-window ----------------
    wb_write(A_CTRL, 32'hF);
    wb_write(A_DUTY0, 32'd2047);
    repeat (1100) @(negedge clk);
    check("pre_rst_pwm0", 32'(pwm[0]), 32'd1);
    check("pre_rst_irq", 32'(irq), 32'd1);
    rd_check("pre_rst_tach2", A_TACH2, 32'd10);
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pwm", 32'(pwm), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_dat", rdat, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_check("post_rst_tach2", A_TACH2, 32'd0);
    rd_check("post_rst_win",   A_WIN,   32'd50_000_000);
    rd_check("post_rst_ctrl",  A_CTRL,  32'd0);
    rd_check("post_rst_stat",  A_STAT,  32'd0);
    rd_check("post_rst_duty0", A_DUTY0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_tach_ctrl.md
Name: pwm_tach_ctrl

Overview:
Parametrised NCH-channel fan controller on the Wishbone peripheral bus, the successor to the single-register PWM and two-input fan counter.
- Each channel has a glitch-free PWM output with 0–100% duty range and shadowed duty update.
- Each channel has a tach input counted over a programmable window, with a latched RPM count.
- Per-channel under-speed/stall detection against a programmable minimum, raising a maskable interrupt to the CPU.

Parameters:
NCH, 4, number of PWM/tach channel pairs (1..6; requires 0x10+8*NCH <= 2**ADR_W)
PWM_W, 10, PWM counter width; period = 2**PWM_W cycles
TCH_W, 16, tach count / min-threshold width (saturating)
WIN_W, 27, window register width
WIN_DEFAULT, 50_000_000, reset window length in cycles (1 s at 50 MHz)
ADR_W, 6, Wishbone byte-address width

Ports:
CLK_I  in  1  system clock
RST_N_I  in  1  asynchronous active-low reset
PTC_STB_I  in  1  Wishbone strobe
PTC_WE_I  in  1  write enable
PTC_ADR_I  in  ADR_W  byte address; [1:0] ignored
PTC_DAT_I  in  32  write data
PTC_SEL_I  in  4  ignored; full-word access only
PTC_ACK_O  out  1  acknowledge
PTC_DAT_O  out  32  read data
PTC_ERR_O  out  1  constant 0
PTC_RTY_O  out  1  constant 0
PWM_O  out  NCH  PWM outputs
TACH_I  in  NCH  asynchronous tach inputs
IRQ_O  out  1  interrupt, level, active-high

Behaviour:
Reset values
- Asynchronous on RST_N_I low: all outputs 0.
- All registers 0, except WIN = WIN_DEFAULT.

Bus
- PTC_ACK_O rises the cycle after PTC_STB_I is sampled with PTC_ACK_O low, and lasts one cycle.
- A write commits on the cycle STB & WE & ~ACK.
- Read data is registered on that same cycle and is valid with ACK.
- Unmapped reads return 0; unmapped writes are dropped.

Register map
- 0x00 CTRL: [NCH-1:0] channel enable.
- 0x04 WIN: [WIN_W-1:0] window length in cycles; 0 = measurement halted.
- 0x08 IRQ_STAT: [NCH-1:0], write-1-to-clear.
- 0x0C IRQ_MASK: [NCH-1:0], 1 = enabled.
- 0x10+8i DUTYi: [PWM_W:0] duty (PWM_W+1 bits); [16+TCH_W-1:16] MINi.
- 0x14+8i TACHi: read-only latched count; writes ignored.

PWM
- A single free-running PWM_W-bit counter pcnt, wrapping 2**PWM_W-1 -> 0.
- Writes land in duty_shadow[i]; duty_act[i] loads from the shadow on the cycle pcnt == 2**PWM_W-1.
- A duty change therefore takes effect from the next period.
- PWM_O[i] is registered: en[i] && (pcnt < duty_act[i]).
- duty 0 = constant low; duty >= 2**PWM_W = constant high.
- A disabled channel outputs 0 immediately; the shadow copy is still updated.

Tach channel (one sub-module per channel)
- 3-flop synchroniser, then falling-edge detect.
- Edge-to-count latency is 3 cycles.
- Running count saturates at 2**TCH_W-1.

Window
- wcnt counts 1..WIN.
- At wcnt == WIN (the terminal cycle), for each channel:
  - TACHi is latched with the running count;
  - the running count restarts at 1 if an edge occurs on the terminal cycle, else at 0 (no edge lost).
- Writing WIN resets wcnt and all running counts to 0; latched TACHi values are kept.
- WIN = 0 holds wcnt and the running counts at 0.

Stall / IRQ
- The cycle after a latch, IRQ_STAT[i] is set if en[i] && TACHi < MINi.
- Set has priority over a simultaneous W1C of the same bit.
- IRQ_O = |(IRQ_STAT & IRQ_MASK), from registers.
- Disabling a channel does not clear its IRQ_STAT bit.

Reset mid-window
- All state returns to the reset values immediately.
- Measurement restarts from wcnt = 0 after reset deasserts.

Decomposition:
- Shared package pwm_tach_pkg:
  - register offsets (CTRL, WIN, IRQ_STAT, IRQ_MASK, CH_BASE, CH_STRIDE, DUTY_OFS, TACH_OFS);
  - MIN field LSB (16);
  - default constants.
- Sub-module tach_chan: synchroniser, edge detect, saturating running count, latch on win_tc.
  - It receives win_tc and win_clr from the top.
  - It outputs the latched count.
- PWM compare, bus decode, window counter and IRQ logic stay in the top.

Test Plan:
- Reset; write DUTY0=256, CTRL=0x1 -> PWM_O[0] high exactly 256 of every 1024 cycles; DUTY0=0 -> constant 0; DUTY0=1024 -> constant 1.
- Write DUTY1=100 then DUTY1=900 mid-period (pcnt=500) -> current period stays 100-high; the next period is 900-high; no runt pulse.
- WIN=1000, TACH_I[1] period 100 cycles -> TACH1 reads 10 after each window; period 2 cycles for 2**17 cycles -> TACH1 saturates at 65535.
- MIN2=20, IRQ_MASK=0x4, CTRL=0x4, tach2 period 100, WIN=1000 -> at the first window end IRQ_STAT=0x4 and IRQ_O=1; write IRQ_STAT=0x4 -> clears; re-sets at the next window end.
- Issue the W1C on the exact set cycle -> bit remains 1; IRQ_MASK=0 -> IRQ_O=0 while IRQ_STAT=0x4.
- Edge on the terminal cycle is counted in the next window; assert RST_N_I mid-window -> PWM_O=0, IRQ_O=0, TACHi=0, WIN reads 50_000_000.
